// File: rtl/pong_pkg.sv
// Shared types and helpers for the pong engine: FSM states, winner codes,
// horizontal direction encoding and the paddle offset-to-direction rule.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_P1   = 2'd1,
      WIN_P2   = 2'd2
   } winner_e;

   typedef enum logic [1:0] {
      DX_NEG  = 2'd0,
      DX_ZERO = 2'd1,
      DX_POS  = 2'd2
   } dx_e;

   // Left part of the paddle kicks left, exact centre goes straight, right part kicks right.
   function automatic dx_e offset_to_dx(input int offset, input int paddle_len);
      if (2 * offset < paddle_len - 1)
         return DX_NEG;
      else if (2 * offset == paddle_len - 1)
         return DX_ZERO;
      else
         return DX_POS;
   endfunction

   function automatic int dx_step(input dx_e d);
      case (d)
         DX_NEG:  return -1;
         DX_POS:  return 1;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: left-column position stepped by up/dn buttons on an enable,
// saturating at 0 and at GRID_W-PADDLE_LEN; both buttons together cancel.
module pong_paddle #(
   parameter int GRID_W     = 8,
   parameter int PADDLE_LEN = 3
) (
   input  logic                      sysclk,
   input  logic                      rst_n,
   input  logic                      step_i,
   input  logic                      up_i,
   input  logic                      dn_i,
   output logic [$clog2(GRID_W)-1:0] pos_o
);

   localparam int PW = $clog2(GRID_W);
   localparam logic [PW-1:0] MAX_POS = PW'(GRID_W - PADDLE_LEN);

   logic [PW-1:0] pos_q, pos_d;

   always_comb begin
      // NOTE: default assigned first so every path drives pos_d and no latch is inferred.
      pos_d = pos_q;
      if (step_i && (up_i ^ dn_i)) begin
         if (up_i && pos_q != '0)
            pos_d = pos_q - 1'b1;
         else if (dn_i && pos_q != MAX_POS)
            pos_d = pos_q + 1'b1;
      end
   end

   always_ff @(posedge sysclk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n)
         pos_q <= '0;
      else
         pos_q <= pos_d;
   end

   assign pos_o = pos_q;

endmodule

// File: rtl/pong_engine.sv
// Two-player pong game engine on a GRID_W x GRID_H cell grid.
// Define PONG_AUTO_P2_EN to let P2 track the ball instead of using its buttons.
module pong_engine
   import pong_pkg::*;
#(
   parameter int GRID_W      = 8,
   parameter int GRID_H      = 8,
   parameter int PADDLE_LEN  = 3,
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_TICKS = 2
) (
   input  logic                      sysclk,
   input  logic                      rst_n,
   input  logic                      ball_tick,
   input  logic                      paddle_tick,
   input  logic                      p1_up,
   input  logic                      p1_dn,
   input  logic                      p2_up,
   input  logic                      p2_dn,
   input  logic                      start,
   output logic [$clog2(GRID_W)-1:0] ball_x,
   output logic [$clog2(GRID_H)-1:0] ball_y,
   output logic [$clog2(GRID_W)-1:0] p1_pos,
   output logic [$clog2(GRID_W)-1:0] p2_pos,
   output logic [3:0]                score1,
   output logic [3:0]                score2,
   output logic [2:0]                state,
   output logic [1:0]                winner,
   output logic                      point_pulse
);

   localparam int XW  = $clog2(GRID_W);
   localparam int YW  = $clog2(GRID_H);
   localparam int SCW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
   localparam logic [XW-1:0] X_MID  = XW'(GRID_W / 2);
   localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MID  = YW'(GRID_H / 2);
   localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);
   localparam logic [3:0]    WIN_PTS = 4'(WIN_SCORE);

   state_e         state_q, state_d;
   logic [XW-1:0]  ball_x_q, ball_x_d;
   logic [YW-1:0]  ball_y_q, ball_y_d;
   dx_e            dx_q, dx_d;
   logic           dy_pos_q, dy_pos_d;
   logic [SCW-1:0] serve_cnt_q, serve_cnt_d;
   logic [3:0]     score1_q, score1_d;
   logic [3:0]     score2_q, score2_d;
   winner_e        winner_q, winner_d;
   logic           pulse_q, pulse_d;

   logic [XW-1:0]  p1_pos_q, p2_pos_q;
   logic           paddle_en, p2_up_eff, p2_dn_eff;
   logic           serve_done, at_row_v, hit_v, dy_v;
   dx_e            dx_v;
   int             off_v;

   function automatic dx_e wall_reflect(input logic [XW-1:0] x, input dx_e d);
      if (x == '0 && d == DX_NEG)
         return DX_POS;
      if (x == X_LAST && d == DX_POS)
         return DX_NEG;
      return d;
   endfunction

   assign serve_done = (SERVE_TICKS == 0) ||
                       (ball_tick && (int'(serve_cnt_q) >= SERVE_TICKS - 1));

   always_comb begin
      state_d     = state_q;
      ball_x_d    = ball_x_q;
      ball_y_d    = ball_y_q;
      dx_d        = dx_q;
      dy_pos_d    = dy_pos_q;
      serve_cnt_d = serve_cnt_q;
      score1_d    = score1_q;
      score2_d    = score2_q;
      winner_d    = winner_q;
      pulse_d     = 1'b0;
      dx_v        = wall_reflect(ball_x_q, dx_q);
      dy_v        = dy_pos_q;
      // Paddle check uses the registered (pre-update) paddle positions.
      at_row_v    = dy_pos_q ? (ball_y_q == Y_LAST) : (ball_y_q == '0);
      off_v       = int'(ball_x_q) - int'(dy_pos_q ? p1_pos_q : p2_pos_q);
      hit_v       = at_row_v && (off_v >= 0) && (off_v < PADDLE_LEN);

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_SERVE;
               ball_x_d    = X_MID;
               ball_y_d    = Y_MID;
               dx_d        = DX_ZERO;
               dy_pos_d    = 1'b1;
               serve_cnt_d = '0;
            end
         end
         ST_SERVE: begin
            if (serve_done) begin
               state_d     = ST_PLAY;
               serve_cnt_d = '0;
            end else if (ball_tick) begin
               serve_cnt_d = serve_cnt_q + 1'b1;
            end
         end
         ST_PLAY: begin
            if (ball_tick) begin
               if (at_row_v && !hit_v) begin
                  // Miss: ball stays put, dy keeps pointing at the conceding player.
                  pulse_d = 1'b1;
                  state_d = ST_POINT;
                  if (dy_pos_q) begin
                     if (score2_q != 4'hF) score2_d = score2_q + 4'd1;
                  end else begin
                     if (score1_q != 4'hF) score1_d = score1_q + 4'd1;
                  end
               end else begin
                  if (hit_v) begin
                     dy_v = ~dy_pos_q;
                     dx_v = wall_reflect(ball_x_q, offset_to_dx(off_v, PADDLE_LEN));
                  end
                  ball_x_d = XW'(int'(ball_x_q) + dx_step(dx_v));
                  ball_y_d = dy_v ? ball_y_q + 1'b1 : ball_y_q - 1'b1;
                  dx_d     = dx_v;
                  dy_pos_d = dy_v;
               end
            end
         end
         ST_POINT: begin
            if (score1_q == WIN_PTS || score2_q == WIN_PTS) begin
               state_d  = ST_OVER;
               winner_d = (score1_q == WIN_PTS) ? WIN_P1 : WIN_P2;
            end else begin
               state_d     = ST_SERVE;
               ball_x_d    = X_MID;
               ball_y_d    = Y_MID;
               dx_d        = DX_ZERO;
               serve_cnt_d = '0;
            end
         end
         ST_OVER: begin
            if (start) begin
               state_d  = ST_IDLE;
               score1_d = '0;
               score2_d = '0;
               winner_d = WIN_NONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ball_x_q    <= X_MID;
         ball_y_q    <= Y_MID;
         dx_q        <= DX_ZERO;
         dy_pos_q    <= 1'b1;
         serve_cnt_q <= '0;
         score1_q    <= '0;
         score2_q    <= '0;
         winner_q    <= WIN_NONE;
         pulse_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ball_x_q    <= ball_x_d;
         ball_y_q    <= ball_y_d;
         dx_q        <= dx_d;
         dy_pos_q    <= dy_pos_d;
         serve_cnt_q <= serve_cnt_d;
         score1_q    <= score1_d;
         score2_q    <= score2_d;
         winner_q    <= winner_d;
         pulse_q     <= pulse_d;
      end
   end

   assign paddle_en = paddle_tick && (state_q != ST_OVER);

`ifdef PONG_AUTO_P2_EN
   int   p2_target;
   logic unused_p2_buttons;
   assign unused_p2_buttons = p2_up ^ p2_dn;
   always_comb begin
      p2_target = int'(ball_x_q) - (PADDLE_LEN - 1) / 2;
      p2_up_eff = int'(p2_pos_q) > p2_target;
      p2_dn_eff = int'(p2_pos_q) < p2_target;
   end
`else
   assign p2_up_eff = p2_up;
   assign p2_dn_eff = p2_dn;
`endif

   pong_paddle #(.GRID_W(GRID_W), .PADDLE_LEN(PADDLE_LEN)) u_p1_paddle (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .step_i (paddle_en),
      .up_i   (p1_up),
      .dn_i   (p1_dn),
      .pos_o  (p1_pos_q)
   );

   pong_paddle #(.GRID_W(GRID_W), .PADDLE_LEN(PADDLE_LEN)) u_p2_paddle (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .step_i (paddle_en),
      .up_i   (p2_up_eff),
      .dn_i   (p2_dn_eff),
      .pos_o  (p2_pos_q)
   );

   assign ball_x      = ball_x_q;
   assign ball_y      = ball_y_q;
   assign p1_pos      = p1_pos_q;
   assign p2_pos      = p2_pos_q;
   assign score1      = score1_q;
   assign score2      = score2_q;
   assign state       = state_q;
   assign winner      = winner_q;
   assign point_pulse = pulse_q;

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine (8x8 grid, paddle 3, win at 3, serve 2 ticks):
// expected outputs are queued per driven cycle and compared after the edge.
module tb_pong_engine;

   localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;
   localparam logic [3:0] P1U = 4'b1000, P1D = 4'b0100, P2U = 4'b0010, P2D = 4'b0001;

   logic       sysclk, rst_n;
   logic       ball_tick, paddle_tick, p1_up, p1_dn, p2_up, p2_dn, start;
   logic [2:0] ball_x, ball_y, p1_pos, p2_pos;
   logic [3:0] score1, score2;
   logic [2:0] state;
   logic [1:0] winner;
   logic       point_pulse;

   typedef struct {
      string tag;
      int    st, bx, by, p1, p2, s1, s2, win, pulse;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   e_st, e_bx, e_by, e_p1, e_p2, e_s1, e_s2, e_win, e_pulse;

   pong_engine #(
      .GRID_W(8), .GRID_H(8), .PADDLE_LEN(3), .WIN_SCORE(3), .SERVE_TICKS(2)
   ) dut (
      .sysclk      (sysclk),
      .rst_n       (rst_n),
      .ball_tick   (ball_tick),
      .paddle_tick (paddle_tick),
      .p1_up       (p1_up),
      .p1_dn       (p1_dn),
      .p2_up       (p2_up),
      .p2_dn       (p2_dn),
      .start       (start),
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .p1_pos      (p1_pos),
      .p2_pos      (p2_pos),
      .score1      (score1),
      .score2      (score2),
      .state       (state),
      .winner      (winner),
      .point_pulse (point_pulse)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input string field,
                        input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s: observed %0d expected %0d", tag, field, obs, exp);
      end
   endtask

   task automatic cyc(input bit bt, input bit pt, input logic [3:0] btn,
                      input bit st, input string tag);
      exp_t e, got;
      ball_tick   = bt;
      paddle_tick = pt;
      {p1_up, p1_dn, p2_up, p2_dn} = btn;
      start       = st;
      e = '{tag, e_st, e_bx, e_by, e_p1, e_p2, e_s1, e_s2, e_win, e_pulse};
      exp_q.push_back(e);
      @(posedge sysclk);
      #1;
      ball_tick = 1'b0; paddle_tick = 1'b0; start = 1'b0;
      {p1_up, p1_dn, p2_up, p2_dn} = 4'b0;
      got = exp_q.pop_front();
      check(got.tag, "state",  32'(state),       32'(got.st));
      check(got.tag, "ball_x", 32'(ball_x),      32'(got.bx));
      check(got.tag, "ball_y", 32'(ball_y),      32'(got.by));
      check(got.tag, "p1_pos", 32'(p1_pos),      32'(got.p1));
      check(got.tag, "p2_pos", 32'(p2_pos),      32'(got.p2));
      check(got.tag, "score1", 32'(score1),      32'(got.s1));
      check(got.tag, "score2", 32'(score2),      32'(got.s2));
      check(got.tag, "winner", 32'(winner),      32'(got.win));
      check(got.tag, "pulse",  32'(point_pulse), 32'(got.pulse));
   endtask

   initial begin
      rst_n = 1'b0;
      ball_tick = 1'b0; paddle_tick = 1'b0; start = 1'b0;
      {p1_up, p1_dn, p2_up, p2_dn} = 4'b0;
      e_st = S_IDLE; e_bx = 4; e_by = 4; e_p1 = 0; e_p2 = 0;
      e_s1 = 0; e_s2 = 0; e_win = 0; e_pulse = 0;

      // Reset wins over ticks, buttons and start.
      cyc(1, 1, P1D | P2D, 1, "reset_overrides");
      cyc(0, 0, 4'b0, 0, "reset_hold");
      rst_n = 1'b1;

      // Paddle stepping and saturation while idle.
      cyc(0, 0, P1D, 0, "no_paddle_tick");
      for (int i = 1; i <= 7; i++) begin
         e_p1 = (i < 5) ? i : 5;
         cyc(0, 1, P1D, 0, "p1_dn_sat");
      end
      cyc(0, 1, P1U | P1D, 0, "p1_both_hold");
      e_p2 = 1; cyc(0, 1, P2D, 0, "p2_dn");
      e_p2 = 0; cyc(0, 1, P2U, 0, "p2_up");
      cyc(0, 1, P2U, 0, "p2_up_sat");
      cyc(1, 0, 4'b0, 0, "idle_ignores_ball");

      // Start, serve hold, then play from centre.
      e_st = S_SERVE; cyc(0, 0, 4'b0, 1, "start_to_serve");
      cyc(0, 0, 4'b0, 0, "serve_waits");
      cyc(1, 0, 4'b0, 0, "serve_tick1");
      e_st = S_PLAY; cyc(1, 0, 4'b0, 0, "serve_tick2_play");
      e_by = 5; e_p1 = 4; cyc(1, 1, P1U, 0, "play_step_p1up");
      e_by = 6; e_p1 = 3; cyc(1, 1, P1U, 0, "play_step_p1up");
      e_by = 7; cyc(1, 0, 4'b0, 0, "reach_p1_row");

      // Hit at offset 1 with a coincident paddle move: check uses p1_pos=3.
      e_by = 6; e_p1 = 2; cyc(1, 1, P1U, 0, "hit_off1_pre_update");
      for (int i = 0; i < 6; i++) begin
         e_by--;
         if (i < 4) e_p2++;
         cyc(1, i < 4, (i < 4) ? P2D : 4'b0, 0, "rise_p2dn");
      end

      // Top hit at offset 0 sends ball left; it reflects off the left wall.
      e_bx = 3; e_by = 1; cyc(1, 0, 4'b0, 0, "hit_off0_top");
      e_bx = 2; e_by = 2; e_p1 = 1; cyc(1, 1, P1U, 0, "diag_p1up");
      e_bx = 1; e_by = 3; cyc(1, 0, 4'b0, 0, "diag");
      e_bx = 0; e_by = 4; cyc(1, 0, 4'b0, 0, "diag_left_wall");
      e_bx = 1; e_by = 5; cyc(1, 0, 4'b0, 0, "left_wall_reflect");
      e_bx = 2; e_by = 6; cyc(1, 0, 4'b0, 0, "diag");
      e_bx = 3; e_by = 7; cyc(1, 0, 4'b0, 0, "diag_p1_row");

      // Bottom hit at offset 2 sends ball right; it reflects off the right wall.
      e_bx = 4; e_by = 6; cyc(1, 0, 4'b0, 0, "hit_off2");
      e_bx = 5; e_by = 5; e_p2 = 3; cyc(1, 1, P2U, 0, "diag_p2up");
      e_bx = 6; e_by = 4; e_p2 = 2; cyc(1, 1, P2U, 0, "diag_p2up");
      e_bx = 7; e_by = 3; e_p2 = 1; cyc(1, 1, P2U, 0, "diag_right_wall");
      e_bx = 6; e_by = 2; e_p2 = 0; cyc(1, 1, P2U, 0, "right_wall_reflect");
      e_bx = 5; e_by = 1; cyc(1, 0, 4'b0, 0, "diag");
      e_bx = 4; e_by = 0; cyc(1, 0, 4'b0, 0, "diag_p2_row");

      // P2 misses (offset 4): point to P1, serve back toward P2.
      e_st = S_POINT; e_s1 = 1; e_pulse = 1; cyc(1, 0, 4'b0, 0, "p2_miss");
      e_st = S_SERVE; e_by = 4; e_pulse = 0; cyc(0, 0, 4'b0, 0, "point_to_serve");
      cyc(1, 0, 4'b0, 0, "serve_tick1");
      e_st = S_PLAY; cyc(1, 0, 4'b0, 0, "serve_tick2_play");
      for (int i = 0; i < 4; i++) begin
         e_by--;
         if (i < 3) e_p2++;
         cyc(1, i < 3, (i < 3) ? P2D : 4'b0, 0, "serve_dy_up");
      end
      e_by = 1; cyc(1, 0, 4'b0, 0, "hit_top_off1");
      for (int i = 0; i < 6; i++) begin
         e_by++;
         cyc(1, 0, 4'b0, 0, "fall");
      end

      // P1 misses at offset 3 (= paddle length): point to P2, serve toward P1.
      e_st = S_POINT; e_s2 = 1; e_pulse = 1; cyc(1, 0, 4'b0, 0, "p1_miss_off3");
      e_st = S_SERVE; e_by = 4; e_pulse = 0; cyc(0, 0, 4'b0, 0, "pulse_one_cycle");
      e_p1 = 2; cyc(1, 1, P1D, 0, "serve_tick1_p1dn");
      e_st = S_PLAY; e_p1 = 3; cyc(1, 1, P1D, 0, "serve_tick2_play");
      for (int i = 0; i < 3; i++) begin
         e_by++;
         cyc(1, 0, 4'b0, 0, "serve_dy_down");
      end
      e_by = 6; cyc(1, 0, 4'b0, 0, "hit_off1_again");
      for (int i = 0; i < 6; i++) begin
         e_by--;
         if (i < 3) e_p2--;
         cyc(1, i < 3, (i < 3) ? P2U : 4'b0, 0, "rise_p2up");
      end
      e_st = S_POINT; e_s1 = 2; e_pulse = 1; cyc(1, 0, 4'b0, 0, "p2_miss2");
      e_st = S_SERVE; e_by = 4; e_pulse = 0; cyc(0, 0, 4'b0, 0, "serve3");
      cyc(1, 0, 4'b0, 0, "serve_tick1");
      e_st = S_PLAY; cyc(1, 0, 4'b0, 0, "serve_tick2_play");
      for (int i = 0; i < 4; i++) begin
         e_by--;
         cyc(1, 0, 4'b0, 0, "rise_to_miss");
      end

      // Third point for P1 ends the game.
      e_st = S_POINT; e_s1 = 3; e_pulse = 1; cyc(1, 0, 4'b0, 0, "p2_miss3");
      e_st = S_OVER; e_win = 1; e_pulse = 0; cyc(0, 0, 4'b0, 0, "over_winner");
      cyc(1, 1, P1D | P2D, 0, "over_frozen");
      e_st = S_IDLE; e_s1 = 0; e_s2 = 0; e_win = 0; cyc(0, 0, 4'b0, 1, "over_start_clears");

      // New game serves toward P1 again.
      e_st = S_SERVE; e_bx = 4; e_by = 4; cyc(0, 0, 4'b0, 1, "restart");
      cyc(1, 0, 4'b0, 0, "serve_tick1");
      e_st = S_PLAY; cyc(1, 0, 4'b0, 0, "serve_tick2_play");
      e_by = 5; cyc(1, 0, 4'b0, 0, "first_serve_dy_down");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pong_engine.md
PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 SHALL have parameter GRID_W, default 8, meaning ball/paddle columns, ≥4.
REQ-002 SHALL have parameter GRID_H, default 8, meaning rows; P1 paddle row GRID_H-1, P2 paddle row 0; ≥4.
REQ-003 SHALL have parameter PADDLE_LEN, default 3, meaning paddle width in cells, 1..GRID_W-1.
REQ-004 SHALL have parameter WIN_SCORE, default 9, meaning points ending a game, 1..15.
REQ-005 SHALL have parameter SERVE_TICKS, default 2, meaning ball_ticks the ball holds at centre before moving.
REQ-006 SHALL have port sysclk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on sysclk rising edge.
REQ-008 SHALL have ports ball_tick and paddle_tick, inputs, 1 bit each: single-cycle step enables.
REQ-009 SHALL have ports p1_up, p1_dn, p2_up, p2_dn, inputs, 1 bit each: level-sensitive paddle buttons.
REQ-010 SHALL have port start, input, 1 bit: level; begins a game from IDLE or clears from OVER.
REQ-011 SHALL have ports ball_x and ball_y, outputs, $clog2(GRID_W) and $clog2(GRID_H) bits: ball cell.
REQ-012 SHALL have ports p1_pos and p2_pos, outputs, $clog2(GRID_W) bits: left column of each paddle.
REQ-013 SHALL have ports score1 and score2, outputs, 4 bits each: saturating point counts.
REQ-014 SHALL have ports state (3 bits), winner (2 bits: 0 none, 1 P1, 2 P2) and point_pulse (1 bit, one cycle per point scored), all outputs.

Function
REQ-015 SHALL use FSM IDLE→(start)→SERVE→(SERVE_TICKS ball_ticks)→PLAY→(miss)→POINT→(next cycle) SERVE, or OVER if a score equals WIN_SCORE; OVER→(start)→IDLE.
REQ-016 SHALL, on entering SERVE, place the ball at (GRID_W/2, GRID_H/2) with dx=0 and dy toward the player who conceded; first serve dy=+1.
REQ-017 SHALL, in PLAY on a ball_tick, apply in order: X-wall reflection, paddle check, move; all registers update at that edge, so latency is 1 cycle.
REQ-018 SHALL perform X-wall reflection: ball_x=0 with dx=-1 gives dx=+1; ball_x=GRID_W-1 with dx=+1 gives dx=-1.
REQ-019 SHALL perform the paddle check when ball_y=0 and dy=-1 against p2_pos, or when ball_y=GRID_H-1 and dy=+1 against p1_pos.
REQ-020 SHALL, for the paddle check, compute offset = ball_x - pos; a hit is 0≤offset<PADDLE_LEN.
REQ-021 SHALL, on a hit, invert dy and set dx=-1 if 2·offset<PADDLE_LEN-1, dx=0 if 2·offset=PADDLE_LEN-1, else dx=+1; reflection then applies if dx points into a wall.
REQ-022 SHALL, on a miss, not move the ball, increment the opposing score, pulse point_pulse, and enter POINT.
REQ-023 SHALL, on a paddle_tick in any state except OVER, move a paddle when its up/dn input is set: up decrements saturating at 0, dn increments saturating at GRID_W-PADDLE_LEN, and both set gives no move.
REQ-024 SHALL, in OVER, set winner to the player whose score equals WIN_SCORE and freeze the ball and paddles.
REQ-025 SHALL, when ball_tick and paddle_tick coincide, process both in the same cycle, with the paddle check using the pre-update paddle positions.
REQ-026 SHALL, on start in OVER, return to IDLE and clear the scores and winner.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set state=IDLE, ball at centre, dx=0, dy=+1, p1_pos=p2_pos=0, scores=0, winner=0, point_pulse=0, serve counter=0, overriding any tick.

Configuration
REQ-028 SHALL, when PONG_AUTO_P2_EN is defined, ignore p2_up/p2_dn and on each paddle_tick step p2_pos one cell toward ball_x-(PADDLE_LEN-1)/2, with the same saturation as REQ-023.
REQ-029 SHALL, when PONG_AUTO_P2_EN is undefined, drive P2 from its buttons per REQ-023.

Structure
REQ-030 SHALL place the FSM state enum, the winner codes and the offset-to-dx function in package pong_pkg.
REQ-031 SHALL implement paddle movement in sub-module pong_paddle, instantiated twice.

Verification (W=H=8, L=3, WIN=3, SERVE_TICKS=2)
REQ-032 SHALL cover reset then start plus 2 ball_ticks: the result is state=PLAY and ball=(4,4).
REQ-033 SHALL cover ball (1,7) with dy=+1, dx=0 and p1_pos=0 on a ball_tick: offset 1 is a hit, giving dy=-1, dx=0, ball (1,6).
REQ-034 SHALL cover ball (0,0) with dy=-1 and p2_pos=0 on a ball_tick: offset 0 gives dx=-1, reflected to +1, so ball (1,1).
REQ-035 SHALL cover ball (6,7) with dy=+1 and p1_pos=0 on a ball_tick: this is a miss, giving score2=1, a one-cycle point_pulse, then SERVE with ball (4,4) and dy=+1.
REQ-036 SHALL cover p1_dn held for 7 paddle_ticks: p1_pos=5, saturated; and p1_up with p1_dn held together: no move.
REQ-037 SHALL cover score1 reaching 3: the result is state=OVER and winner=1; start then gives IDLE with both scores=0.
